// File: rtl/uart_rx.sv
// Oversampling UART receiver: start 0, DATA_WIDTH bits LSB first, optional
// parity, stop 1. Recovered bytes are presented on P_DATA with a 1-cycle
// Data_Valid strobe. Parity and stop errors are reported as 1-cycle strobes.
module uart_rx #(
    parameter int unsigned PRESCALE   = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  parity_enable,
    input  logic                  parity_type,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  parity_error,
    output logic                  stop_error
);

    localparam int unsigned EW = $clog2(PRESCALE);
    localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q;
    logic                  sync1_q;
    logic                  rx_s_q;
    logic [EW-1:0]         edge_cnt_q;
    logic [BW-1:0]         bit_cnt_q;
    logic [2:0]            smp_q;
    logic                  par_en_q;
    logic                  par_type_q;
    logic                  par_err_q;
    logic                  brk_q;
    logic [DATA_WIDTH-1:0] shift_q;

    logic bit_c;
    logic last_edge_c;

    // Majority vote of the three mid-bit samples and end-of-bit detect.
    always_comb begin
        bit_c       = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
        last_edge_c = (edge_cnt_q == EW'(PRESCALE - 1));
    end

    // Synchronizer, bit timing, frame FSM and registered strobes.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            sync1_q      <= 1'b1;
            rx_s_q       <= 1'b1;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            smp_q        <= '0;
            par_en_q     <= 1'b0;
            par_type_q   <= 1'b0;
            par_err_q    <= 1'b0;
            brk_q        <= 1'b0;
            shift_q      <= '0;
            P_DATA       <= '0;
            Data_Valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
        end else begin
            sync1_q      <= RX_IN;
            rx_s_q       <= sync1_q;
            Data_Valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;

            // A break is only cleared once the line has returned high.
            if (rx_s_q) begin
                brk_q <= 1'b0;
            end

            if (state_q != S_IDLE) begin
                if (edge_cnt_q == EW'(PRESCALE / 2 - 1)) smp_q[0] <= rx_s_q;
                if (edge_cnt_q == EW'(PRESCALE / 2))     smp_q[1] <= rx_s_q;
                if (edge_cnt_q == EW'(PRESCALE / 2 + 1)) smp_q[2] <= rx_s_q;
                edge_cnt_q <= last_edge_c ? '0 : edge_cnt_q + EW'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q && !brk_q) begin
                        state_q    <= S_START;
                        edge_cnt_q <= '0;
                        par_en_q   <= parity_enable;
                        par_type_q <= parity_type;
                        par_err_q  <= 1'b0;
                    end
                end
                S_START: begin
                    if (last_edge_c) begin
                        if (bit_c) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q   <= S_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (last_edge_c) begin
                        shift_q <= {bit_c, shift_q[DATA_WIDTH-1:1]};
                        if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
                            state_q <= par_en_q ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (last_edge_c) begin
                        par_err_q <= (bit_c != ((^shift_q) ^ par_type_q));
                        state_q   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (last_edge_c) begin
                        stop_error   <= ~bit_c;
                        parity_error <= par_err_q;
                        if (bit_c && !par_err_q) begin
                            P_DATA     <= shift_q;
                            Data_Valid <= 1'b1;
                        end
                        if (!bit_c) begin
                            // Framing error: wait for the line to go high again.
                            state_q <= S_IDLE;
                            brk_q   <= 1'b1;
                        end else if (!rx_s_q) begin
                            // Start bit right after the stop: no idle cycle lost.
                            state_q    <= S_START;
                            edge_cnt_q <= '0;
                            par_en_q   <= parity_enable;
                            par_type_q <= parity_type;
                            par_err_q  <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx (PRESCALE=8, DATA_WIDTH=8).
module tb_uart_rx;

    localparam int unsigned P = 8;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic       parity_enable = 1'b0;
    logic       parity_type = 1'b0;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       parity_error;
    logic       stop_error;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int         dv_cyc[$];
    logic [7:0] dv_dat[$];
    int         pe_cyc[$];
    int         se_cyc[$];

    uart_rx #(.PRESCALE(P), .DATA_WIDTH(8)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .parity_enable(parity_enable),
        .parity_type  (parity_type),
        .P_DATA       (P_DATA),
        .Data_Valid   (Data_Valid),
        .parity_error (parity_error),
        .stop_error   (stop_error)
    );

    always #5 CLK = ~CLK;

    // Posedge counter: at a negedge, cyc equals the number of the last posedge.
    always @(posedge CLK) cyc <= cyc + 1;

    // Strobe recorder, sampled on the falling edge.
    always @(negedge CLK) begin
        if (Data_Valid) begin
            dv_cyc.push_back(cyc);
            dv_dat.push_back(P_DATA);
        end
        if (parity_error) pe_cyc.push_back(cyc);
        if (stop_error)   se_cyc.push_back(cyc);
    end

    task automatic clear_q();
        dv_cyc.delete();
        dv_dat.delete();
        pe_cyc.delete();
        se_cyc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Drives one frame; glitch inverts the line for one cycle at that index.
    // e0 is the posedge that first captures the start bit.
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                              input logic sbit, input int glitch, output int e0);
        logic fb [0:10];
        int   nb;
        fb[0] = 1'b0;
        for (int j = 0; j < 8; j++) fb[j+1] = d[j];
        fb[10] = 1'b1;
        if (pen) begin
            fb[9]  = pbit;
            fb[10] = sbit;
            nb     = 11;
        end else begin
            fb[9] = sbit;
            nb    = 10;
        end
        e0 = 0;
        for (int i = 0; i < nb * int'(P); i++) begin
            @(negedge CLK);
            if (i == 0) e0 = cyc + 1;
            RX_IN = fb[i / int'(P)] ^ (i == glitch);
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        idle(3);
        checks++; if (P_DATA !== 8'h00) begin failures++; $display("FAIL reset_pdata got=%h exp=00", P_DATA); end
        checks++; if (Data_Valid !== 1'b0) begin failures++; $display("FAIL reset_dv got=%b exp=0", Data_Valid); end
        checks++; if (parity_error !== 1'b0) begin failures++; $display("FAIL reset_pe got=%b exp=0", parity_error); end
        checks++; if (stop_error !== 1'b0) begin failures++; $display("FAIL reset_se got=%b exp=0", stop_error); end
        RST = 1'b1;
        idle(4);
    endtask

    task automatic test_basic();
        int e0;
        clear_q();
        parity_enable = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1, e0);
        idle(10);
        checks++; if (dv_cyc.size() !== 1) begin failures++; $display("FAIL basic_dv_count got=%0d exp=1", dv_cyc.size()); end
        if (dv_cyc.size() == 1) begin
            checks++; if (dv_dat[0] !== 8'hA5) begin failures++; $display("FAIL basic_data got=%h exp=a5", dv_dat[0]); end
            checks++; if (dv_cyc[0] !== e0 + 82) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", dv_cyc[0], e0 + 82); end
        end
        checks++; if (pe_cyc.size() + se_cyc.size() !== 0) begin failures++; $display("FAIL basic_errors got=%0d exp=0", pe_cyc.size() + se_cyc.size()); end
    endtask

    task automatic test_parity();
        int e0;
        clear_q();
        parity_enable = 1'b1;
        parity_type   = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, -1, e0);
        idle(12);
        checks++; if (dv_cyc.size() !== 1) begin failures++; $display("FAIL par_even_dv_count got=%0d exp=1", dv_cyc.size()); end
        if (dv_cyc.size() == 1) begin
            checks++; if (dv_dat[0] !== 8'h3C) begin failures++; $display("FAIL par_even_data got=%h exp=3c", dv_dat[0]); end
            checks++; if (dv_cyc[0] !== e0 + 90) begin failures++; $display("FAIL par_even_latency got=%0d exp=%0d", dv_cyc[0], e0 + 90); end
        end
        // Wrong parity bit.
        clear_q();
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, -1, e0);
        idle(12);
        checks++; if (dv_cyc.size() !== 0) begin failures++; $display("FAIL par_bad_dv got=%0d exp=0", dv_cyc.size()); end
        checks++; if (pe_cyc.size() !== 1) begin failures++; $display("FAIL par_bad_pe_count got=%0d exp=1", pe_cyc.size()); end
        if (pe_cyc.size() == 1) begin
            checks++; if (pe_cyc[0] !== e0 + 90) begin failures++; $display("FAIL par_bad_pe_cycle got=%0d exp=%0d", pe_cyc[0], e0 + 90); end
        end
        checks++; if (P_DATA !== 8'h3C) begin failures++; $display("FAIL par_bad_hold got=%h exp=3c", P_DATA); end
        // Odd parity, configuration changed mid-frame must be ignored.
        clear_q();
        parity_type = 1'b1;
        fork
            send_frame(8'h96, 1'b1, 1'b1, 1'b1, -1, e0);
            begin idle(30); parity_type = 1'b0; parity_enable = 1'b0; end
        join
        idle(12);
        checks++; if (dv_cyc.size() !== 1) begin failures++; $display("FAIL par_odd_dv_count got=%0d exp=1", dv_cyc.size()); end
        if (dv_cyc.size() == 1) begin
            checks++; if (dv_dat[0] !== 8'h96) begin failures++; $display("FAIL par_odd_data got=%h exp=96", dv_dat[0]); end
        end
        parity_enable = 1'b0;
        parity_type   = 1'b0;
    endtask

    task automatic test_stop_error();
        int e0;
        clear_q();
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, -1, e0);
        RX_IN = 1'b1;
        idle(12);
        checks++; if (se_cyc.size() !== 1) begin failures++; $display("FAIL stop_se_count got=%0d exp=1", se_cyc.size()); end
        if (se_cyc.size() == 1) begin
            checks++; if (se_cyc[0] !== e0 + 82) begin failures++; $display("FAIL stop_se_cycle got=%0d exp=%0d", se_cyc[0], e0 + 82); end
        end
        checks++; if (dv_cyc.size() + pe_cyc.size() !== 0) begin failures++; $display("FAIL stop_other_strobes got=%0d exp=0", dv_cyc.size() + pe_cyc.size()); end
        checks++; if (P_DATA !== 8'h96) begin failures++; $display("FAIL stop_hold got=%h exp=96", P_DATA); end
        clear_q();
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, -1, e0);
        idle(10);
        checks++; if (dv_cyc.size() !== 1) begin failures++; $display("FAIL stop_next_dv_count got=%0d exp=1", dv_cyc.size()); end
        if (dv_cyc.size() == 1) begin
            checks++; if (dv_dat[0] !== 8'h55) begin failures++; $display("FAIL stop_next_data got=%h exp=55", dv_dat[0]); end
        end
    endtask

    task automatic test_glitch();
        int e0;
        clear_q();
        @(negedge CLK); RX_IN = 1'b0;
        idle(3);
        RX_IN = 1'b1;
        idle(20);
        checks++; if (dv_cyc.size() + pe_cyc.size() + se_cyc.size() !== 0) begin failures++; $display("FAIL glitch_strobes got=%0d exp=0", dv_cyc.size() + pe_cyc.size() + se_cyc.size()); end
        // Single-cycle low on the mid sample of data bit 3.
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 4 * int'(P) + 5, e0);
        idle(10);
        checks++; if (dv_cyc.size() !== 1) begin failures++; $display("FAIL vote_dv_count got=%0d exp=1", dv_cyc.size()); end
        if (dv_cyc.size() == 1) begin
            checks++; if (dv_dat[0] !== 8'hFF) begin failures++; $display("FAIL vote_data got=%h exp=ff", dv_dat[0]); end
            checks++; if (dv_cyc[0] !== e0 + 82) begin failures++; $display("FAIL vote_latency got=%0d exp=%0d", dv_cyc[0], e0 + 82); end
        end
    endtask

    task automatic test_back_to_back();
        int e0;
        int e1;
        int e2;
        logic [7:0] exp_d [0:2];
        int exp_c [0:2];
        clear_q();
        send_frame(8'h00, 1'b0, 1'b0, 1'b1, -1, e0);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, -1, e1);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, -1, e2);
        idle(10);
        exp_d[0] = 8'h00; exp_d[1] = 8'hFF; exp_d[2] = 8'h5A;
        exp_c[0] = e0 + 82; exp_c[1] = e0 + 162; exp_c[2] = e0 + 242;
        checks++; if (dv_cyc.size() !== 3) begin failures++; $display("FAIL b2b_dv_count got=%0d exp=3", dv_cyc.size()); end
        if (dv_cyc.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                checks++; if (dv_dat[k] !== exp_d[k]) begin failures++; $display("FAIL b2b_data%0d got=%h exp=%h", k, dv_dat[k], exp_d[k]); end
                checks++; if (dv_cyc[k] !== exp_c[k]) begin failures++; $display("FAIL b2b_cycle%0d got=%0d exp=%0d", k, dv_cyc[k], exp_c[k]); end
            end
        end
        checks++; if (pe_cyc.size() + se_cyc.size() !== 0) begin failures++; $display("FAIL b2b_errors got=%0d exp=0", pe_cyc.size() + se_cyc.size()); end
    endtask

    task automatic test_reset_midframe();
        int e0;
        clear_q();
        fork
            send_frame(8'h12, 1'b0, 1'b0, 1'b1, -1, e0);
            begin
                idle(40);
                RST = 1'b0;
                @(negedge CLK);
                checks++; if (P_DATA !== 8'h00) begin failures++; $display("FAIL midrst_pdata got=%h exp=00", P_DATA); end
                checks++; if ({Data_Valid, parity_error, stop_error} !== 3'b000) begin failures++; $display("FAIL midrst_strobes got=%b exp=000", {Data_Valid, parity_error, stop_error}); end
            end
        join
        idle(2);
        RST = 1'b1;
        idle(20);
        checks++; if (dv_cyc.size() + pe_cyc.size() + se_cyc.size() !== 0) begin failures++; $display("FAIL midrst_no_pulse got=%0d exp=0", dv_cyc.size() + pe_cyc.size() + se_cyc.size()); end
        send_frame(8'h34, 1'b0, 1'b0, 1'b1, -1, e0);
        idle(10);
        checks++; if (dv_cyc.size() !== 1) begin failures++; $display("FAIL midrst_next_count got=%0d exp=1", dv_cyc.size()); end
        if (dv_cyc.size() == 1) begin
            checks++; if (dv_dat[0] !== 8'h34) begin failures++; $display("FAIL midrst_next_data got=%h exp=34", dv_dat[0]); end
            checks++; if (dv_cyc[0] !== e0 + 82) begin failures++; $display("FAIL midrst_next_latency got=%0d exp=%0d", dv_cyc[0], e0 + 82); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_stop_error();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
